// File: rtl/seg7_capture_pkg.sv
// Shared definitions for the 7-segment capture block.
// Holds the capture FSM state type, the queued entry layout, the
// hexadecimal segment encodings (bit0 = a .. bit6 = g) and the blank pattern.
package seg7_capture_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  typedef struct packed {
    logic       invalid;
    logic [3:0] digit;
  } entry_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern decoder.
//   pattern : segment pattern, bit0 = a .. bit6 = g
//   digit   : hex value of a recognised pattern, 0 otherwise
//   valid   : pattern is one of the 16 hex encodings
//   blank   : pattern is all segments off
module seg7_to_hex
  import seg7_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid,
  output logic       blank
);

  always_comb begin
    digit = '0;
    valid = 1'b1;
    blank = (pattern == SEG_BLANK);
    case (pattern)
      SEG_HEX_0: digit = 4'h0;
      SEG_HEX_1: digit = 4'h1;
      SEG_HEX_2: digit = 4'h2;
      SEG_HEX_3: digit = 4'h3;
      SEG_HEX_4: digit = 4'h4;
      SEG_HEX_5: digit = 4'h5;
      SEG_HEX_6: digit = 4'h6;
      SEG_HEX_7: digit = 4'h7;
      SEG_HEX_8: digit = 4'h8;
      SEG_HEX_9: digit = 4'h9;
      SEG_HEX_A: digit = 4'hA;
      SEG_HEX_B: digit = 4'hB;
      SEG_HEX_C: digit = 4'hC;
      SEG_HEX_D: digit = 4'hD;
      SEG_HEX_E: digit = 4'hE;
      SEG_HEX_F: digit = 4'hF;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures steady patterns from an asynchronous 7-segment bus, decodes them
// to hex and queues the results for a ready/valid consumer.
//   clk, rst_n     : clock, asynchronous active-low reset
//   ena            : capture enable
//   seg_in         : asynchronous segment bus (bit0 = a .. bit6 = g)
//   out_valid      : queue head holds an entry
//   out_ready      : consumer takes the head when out_valid is high
//   out_digit      : head hex value
//   out_invalid    : head entry came from an undecodable pattern
//   overflow       : sticky, an accepted entry was dropped on a full queue
//   err_count      : saturating count of undecodable patterns accepted
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_invalid,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // The load edge already holds one synchronized sample and the second
  // synchronizer stage carried the new value one edge earlier, so acceptance
  // fires one count early to land on the (STABLE_CYCLES+1)th input edge.
  localparam logic [7:0] ACCEPT_AT =
    (STABLE_CYCLES > 1) ? 8'(STABLE_CYCLES - 1) : 8'd1;

  logic [6:0] sync_meta, sync;
  state_t     state;
  logic [6:0] cand, last_acc;
  logic [7:0] cnt;
  logic       accept, push, pop, full, empty, push_ok;
  logic [3:0] hex_digit;
  logic       hex_valid, hex_blank;
  entry_t     new_entry, head;
  entry_t     mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= seg_in;
      sync      <= sync_meta;
    end
  end

  seg7_to_hex u_dec (
    .pattern (sync),
    .digit   (hex_digit),
    .valid   (hex_valid),
    .blank   (hex_blank)
  );

  always_comb begin
    accept = 1'b0;
    if (ena) begin
      case (state)
        IDLE, LOCKED: accept = (sync != cand) && (ACCEPT_AT == 8'd1);
        SETTLING:     accept = (sync == cand) && ((cnt + 8'd1) == ACCEPT_AT);
        default:      accept = 1'b0;
      endcase
    end
  end

  // last_acc blocks a pattern that glitched away and back from being queued twice.
  assign push = accept && (sync != last_acc) && !hex_blank;

  always_comb begin
    new_entry.invalid = !hex_valid;
    new_entry.digit   = hex_valid ? hex_digit : 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= SEG_BLANK;
      cnt       <= '0;
      last_acc  <= SEG_BLANK;
      err_count <= '0;
    end else if (!ena) begin
      state    <= IDLE;
      cand     <= SEG_BLANK;
      cnt      <= '0;
      last_acc <= SEG_BLANK;
    end else begin
      case (state)
        IDLE, LOCKED: begin
          if (sync != cand) begin
            cand  <= sync;
            cnt   <= 8'd1;
            state <= accept ? LOCKED : SETTLING;
          end
        end
        SETTLING: begin
          if (sync != cand) begin
            cand <= sync;
            cnt  <= 8'd1;
          end else if (accept) begin
            state <= LOCKED;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) last_acc <= sync;
      if (push && !hex_valid && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && out_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW + 1)'(1);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= new_entry;
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign out_valid   = !empty;
  assign out_digit   = empty ? 4'h0 : head.digit;
  assign out_invalid = empty ? 1'b0 : head.invalid;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: a scoreboard queue receives the
// expected entries as patterns are driven and is compared when popped.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst_n, ena, out_ready;
  logic [6:0] seg_in;
  logic       out_valid, out_invalid, overflow;
  logic [3:0] out_digit;
  logic [7:0] err_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [4:0]  sb [$];
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0]  model_last, cur;
  int unsigned run;
  bit          done;
  logic        ovf_m;
  int unsigned err_m;

  seg7_capture #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .seg_in      (seg_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_digit   (out_digit),
    .out_invalid (out_invalid),
    .overflow    (overflow),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected effect of the DUT accepting pattern p.
  task automatic model_accept(input logic [6:0] p);
    logic [4:0] e;
    bit found;
    if (p == model_last) return;
    model_last = p;
    if (p == 7'h00) return;
    found = 0;
    e = 5'h10;
    for (int i = 0; i < 16; i++)
      if (hex_tab[i] == p) begin
        e = {1'b0, 4'(i)};
        found = 1;
      end
    if (!found && err_m < 255) err_m++;
    if (sb.size() < 4) sb.push_back(e);
    else ovf_m = 1'b1;
  endtask

  task automatic hold(input logic [6:0] p, input int unsigned n);
    seg_in = p;
    if (p != cur) begin
      cur  = p;
      run  = 0;
      done = 0;
    end
    run += n;
    if (ena && !done && run >= 5) begin
      done = 1;
      model_accept(p);
    end
    tick(n);
    if (sb.size() > 0) check("head", {out_valid, out_invalid, out_digit}, {1'b1, sb[0]});
    else check("empty_out", {out_valid, out_invalid, out_digit}, 6'h0);
  endtask

  task automatic drain(input string tag);
    int unsigned budget = 64;
    logic [4:0] e;
    out_ready = 1'b1;
    while (out_valid && budget > 0) begin
      if (sb.size() == 0) check({tag, "_extra"}, out_valid, 0);
      else begin
        e = sb.pop_front();
        check({tag, "_entry"}, {out_invalid, out_digit}, e);
      end
      tick(1);
      budget--;
    end
    out_ready = 1'b0;
    if (budget == 0) check({tag, "_timeout"}, out_valid, 0);
    check({tag, "_missing"}, sb.size(), 0);
    check({tag, "_idle_out"}, {out_valid, out_invalid, out_digit}, 6'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_digit", {out_invalid, out_digit}, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err_count, 0);
    tick(2);
    sb.delete();
    ovf_m = 1'b0;
    err_m = 0;
    model_last = 7'h00;
    run = 0;
    done = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; seg_in = 7'h00; out_ready = 1'b0;
    model_last = 7'h00; cur = 7'h00; run = 0; done = 0; ovf_m = 1'b0; err_m = 0;
    #1;
    check("init_valid", out_valid, 0);
    check("init_head", {out_invalid, out_digit}, 0);
    check("init_ovf", overflow, 0);
    check("init_err", err_count, 0);
    tick(2);
    rst_n = 1'b1;
    ena = 1'b1;
    tick(2);

    // Latency: 0x5B steady, out_valid rises after the 5th edge.
    seg_in = 7'h5B; cur = 7'h5B; run = 10; done = 1;
    model_accept(7'h5B);
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      check("lat_valid", out_valid, (e == 5));
    end
    tick(5);
    check("lat_head", {out_invalid, out_digit}, sb[0]);
    drain("lat");

    // Bouncing between 0x06 and 0x4F never settles; steady 0x4F does.
    for (int i = 0; i < 5; i++) begin
      hold(7'h06, 2);
      hold(7'h4F, 2);
    end
    hold(7'h4F, 10);
    drain("bounce");

    // Digits separated by blanks fill the queue; the fifth is dropped.
    begin
      logic [6:0] seq [9] = '{7'h3F, 7'h00, 7'h06, 7'h00, 7'h5B, 7'h00, 7'h4F, 7'h00, 7'h66};
      foreach (seq[i]) hold(seq[i], 8);
    end
    check("ovf_set", overflow, ovf_m);
    drain("fill");
    check("ovf_sticky", overflow, ovf_m);

    // Full queue with a pop on the push edge: no overflow, head advances.
    hold(7'h00, 8);
    apply_reset();
    hold(7'h7F, 8);
    hold(7'h6F, 8);
    hold(7'h77, 8);
    hold(7'h7C, 8);
    seg_in = 7'h39; cur = 7'h39; run = 8; done = 1;
    tick(4);
    check("full_head", {out_valid, out_invalid, out_digit}, {1'b1, sb[0]});
    out_ready = 1'b1;
    tick(1);
    void'(sb.pop_front());
    model_accept(7'h39);
    out_ready = 1'b0;
    check("full_no_ovf", overflow, ovf_m);
    check("full_advance", {out_valid, out_invalid, out_digit}, {1'b1, sb[0]});
    tick(3);
    drain("full");

    // Reset mid-settling with two queued entries discards everything.
    hold(7'h5E, 8);
    hold(7'h79, 8);
    check("pre_rst_count", out_valid, 1);
    seg_in = 7'h71; cur = 7'h71; run = 0; done = 0;
    tick(3);
    apply_reset();
    done = 1;
    model_accept(7'h71);
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      check("rst_relat", out_valid, (e == 5));
    end
    check("rst_head", {out_invalid, out_digit}, sb[0]);
    drain("rst");

    // Undecodable patterns: error entry, saturating error counter.
    hold(7'h55, 8);
    check("err_one", err_count, err_m);
    drain("err1");
    for (int i = 0; i < 300; i++) begin
      hold(7'h00, 8);
      hold(7'h55, 8);
    end
    check("err_sat", err_count, err_m);
    check("err_ovf", overflow, ovf_m);
    drain("err_sat");

    // Capture disabled: no push; re-enable restarts from a blank candidate.
    ena = 1'b0;
    model_last = 7'h00;
    seg_in = 7'h06;
    tick(8);
    check("ena_off", out_valid, 0);
    ena = 1'b1;
    cur = 7'h06; run = 8; done = 1;
    model_accept(7'h06);
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      check("ena_relat", out_valid, (e == 3));
    end
    drain("ena");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
